rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Schedules the single register-file write port between two writeback sources:
//  src0 (execute/ALU pipe) and src1 (load return from non-ideal memory/cache).
//  Each source has a DEPTH-entry FIFO; round-robin arbitration drains heads into regFile.
//  Decode uses the pending-write query ports to stall on buffered, unretired writes.
// PARAMETERS
//  REGWIDTH  16  data width of one register
//  SELW       3  register select width (8 registers)
//  DEPTH      2  entries per source FIFO; power of 2, >=2
// PORTS
//  clk          in   1         clock; all state changes on rising edge
//  rst          in   1         synchronous, active-high reset
//  s0_valid     in   1         src0 write request valid
//  s0_ready     out  1         src0 FIFO can accept
//  s0_sel       in   SELW      src0 destination register
//  s0_data      in   REGWIDTH  src0 write data
//  s1_valid     in   1         src1 write request valid
//  s1_ready     out  1         src1 FIFO can accept
//  s1_sel       in   SELW      src1 destination register
//  s1_data      in   REGWIDTH  src1 write data
//  wr_en        out  1         to regFile writeEn
//  wr_sel       out  SELW      to regFile writeRegSel
//  wr_data      out  REGWIDTH  to regFile writeData
//  q_sel1       in   SELW      pending query, operand 1
//  q_sel2       in   SELW      pending query, operand 2
//  q_pend1      out  1         a buffered write to q_sel1 exists
//  q_pend2      out  1         a buffered write to q_sel2 exists
//  err          out  1         ordering-hazard flag (registered, 1-cycle pulse)
// BEHAVIOUR
//  - Reset (rst=1 at edge): both FIFOs emptied, rd/wr ptrs=0, counts=0, rr_last=1, err=0.
//    While rst=1: s0_ready=s1_ready=0, wr_en=0, q_pend*=0. Mid-operation reset discards entries.
//  - Accept: push when sX_valid & sX_ready at edge. sX_ready = ~rst & (countX != DEPTH).
//    Full FIFO: ready=0 even if a pop happens the same cycle (no pass-through).
//  - Count width clog2(DEPTH)+1; range 0..DEPTH; ptrs wrap modulo DEPTH.
//  - Latency: entry accepted at edge t is eligible from cycle t+1; earliest regFile
//    capture at edge t+2. No combinational path from sX_* inputs to wr_* outputs.
//  - Grant (combinational from state): only one nonempty -> grant it; both nonempty ->
//    grant source != rr_last; none -> wr_en=0, wr_sel/wr_data=0.
//  - wr_en=1 whenever a grant exists; wr_sel/wr_data = granted FIFO head.
//    Granted head pops at the same edge; rr_last <= granted source.
//  - Simultaneous push+pop on one FIFO: count unchanged, both ptrs advance.
//  - q_pendN = OR over valid entries of both FIFOs of (entry.sel == q_selN);
//    excludes in-flight sX_* inputs not yet accepted. Head being written this cycle counts.
//  - err <= 1 for one cycle after an accept whose sel matches a valid entry in the
//    OTHER source's FIFO (cross-source WAW; order not guaranteed). Entry still accepted.
//    Both sources accepted same cycle with equal sel also sets err. Same-source: no err.
// TESTING
//  1 rst 2 cycles -> s0/s1_ready=0, wr_en=0, err=0; release -> ready=1 next cycle.
//  2 s0 push sel=3,data=16'hBEEF at edge t -> wr_en=1,wr_sel=3,wr_data=BEEF in cycle t+1 only.
//  3 Preload s0{r1=1,r2=2}, s1{r5=5,r6=6} -> write order r1,r5,r2,r6 (src0 first after rst).
//  4 Stall drain (no pops impossible) -> hold s0_valid 3 cycles at full: 3rd push
//    refused while count=DEPTH; entries drain in FIFO order, no loss/duplication.
//  5 s1 entry sel=4 buffered; q_sel1=4 -> q_pend1=1, q_sel2=2 -> q_pend2=0;
//    after drain q_pend1=0.
//  6 s0 holds sel=7, s1 pushes sel=7 -> err=1 one cycle; assert rst with
//    entries buffered -> next cycle FIFOs empty, wr_en=0, q_pend*=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two small FIFOs (ALU and load return) drained
// round-robin into the single regFile write port, with pending-write query and WAW flag.
module rf_wb_arbiter #(
   parameter int REGWIDTH = 16,
   parameter int SELW     = 3,
   parameter int DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s0_valid,
   output logic                s0_ready,
   input  logic [SELW-1:0]     s0_sel,
   input  logic [REGWIDTH-1:0] s0_data,
   input  logic                s1_valid,
   output logic                s1_ready,
   input  logic [SELW-1:0]     s1_sel,
   input  logic [REGWIDTH-1:0] s1_data,
   output logic                wr_en,
   output logic [SELW-1:0]     wr_sel,
   output logic [REGWIDTH-1:0] wr_data,
   input  logic [SELW-1:0]     q_sel1,
   input  logic [SELW-1:0]     q_sel2,
   output logic                q_pend1,
   output logic                q_pend2,
   output logic                err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [SELW-1:0]     sel_q  [2][DEPTH];
   logic [REGWIDTH-1:0] data_q [2][DEPTH];
   logic [PW-1:0]       wp_q   [2];
   logic [PW-1:0]       rp_q   [2];
   logic [CW-1:0]       cnt_q  [2];
   logic                rr_last_q;
   logic                err_q;
   logic                err_d;

   logic                in_valid [2];
   logic [SELW-1:0]     in_sel   [2];
   logic [REGWIDTH-1:0] in_data  [2];
   logic                ready    [2];
   logic                push     [2];
   logic                pop      [2];
   logic                nonempty [2];
   logic                hit      [2];
   logic [DEPTH-1:0]    ent_v    [2];

   assign in_valid[0] = s0_valid;
   assign in_valid[1] = s1_valid;
   assign in_sel[0]   = s0_sel;
   assign in_sel[1]   = s1_sel;
   assign in_data[0]  = s0_data;
   assign in_data[1]  = s1_data;

   // Occupancy, acceptance and which slots hold live entries (offset from head < count).
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         nonempty[i] = (cnt_q[i] != '0);
         ready[i]    = ~rst & (cnt_q[i] != FULL);
         push[i]     = in_valid[i] & ready[i];
         for (int j = 0; j < DEPTH; j++) begin
            ent_v[i][j] = ({1'b0, PW'(j) - rp_q[i]} < cnt_q[i]);
         end
      end
   end

   assign s0_ready = ready[0];
   assign s1_ready = ready[1];

   // Grant purely from state; round-robin only matters when both FIFOs hold entries.
   always_comb begin
      pop[0] = ~rst & nonempty[0] & (~nonempty[1] | rr_last_q);
      pop[1] = ~rst & nonempty[1] & (~nonempty[0] | ~rr_last_q);
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      wr_en   = 1'b0;
      wr_sel  = '0;
      wr_data = '0;
      if (pop[1]) begin
         wr_en   = 1'b1;
         wr_sel  = sel_q[1][rp_q[1]];
         wr_data = data_q[1][rp_q[1]];
      end else if (pop[0]) begin
         wr_en   = 1'b1;
         wr_sel  = sel_q[0][rp_q[0]];
         wr_data = data_q[0][rp_q[0]];
      end
   end

   // Pending query and cross-source match over every live entry, head included.
   always_comb begin
      q_pend1 = 1'b0;
      q_pend2 = 1'b0;
      hit[0]  = 1'b0;
      hit[1]  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (ent_v[i][j]) begin
               q_pend1 = q_pend1 | (sel_q[i][j] == q_sel1);
               q_pend2 = q_pend2 | (sel_q[i][j] == q_sel2);
               hit[1-i] = hit[1-i] | (sel_q[i][j] == in_sel[1-i]);
            end
         end
      end
      q_pend1 = q_pend1 & ~rst;
      q_pend2 = q_pend2 & ~rst;
   end

   always_comb begin
      err_d = (push[0] & hit[0]) | (push[1] & hit[1]) |
              (push[0] & push[1] & (in_sel[0] == in_sel[1]));
   end

   assign err = err_q;

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         rr_last_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
            if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
            cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         end
         if (pop[0] | pop[1]) rr_last_q <= pop[1];
         err_q <= err_d;
      end
   end

   // NOTE: storage is not reset; the pointers and counts alone define which slots are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            sel_q[i][wp_q[i]]  <= in_sel[i];
            data_q[i][wp_q[i]] <= in_data[i];
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue-based reference model, directed
// scenarios followed by randomized traffic with occasional resets.
module tb_rf_wb_arbiter;

   localparam int REGWIDTH = 16;
   localparam int SELW     = 3;
   localparam int DEPTH    = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic                s0_valid, s1_valid;
   logic                s0_ready, s1_ready;
   logic [SELW-1:0]     s0_sel, s1_sel;
   logic [REGWIDTH-1:0] s0_data, s1_data;
   logic                wr_en;
   logic [SELW-1:0]     wr_sel;
   logic [REGWIDTH-1:0] wr_data;
   logic [SELW-1:0]     q_sel1, q_sel2;
   logic                q_pend1, q_pend2;
   logic                err;

   rf_wb_arbiter #(.REGWIDTH(REGWIDTH), .SELW(SELW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_sel(s0_sel), .s0_data(s0_data),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_sel(s1_sel), .s1_data(s1_data),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .q_sel1(q_sel1), .q_sel2(q_sel2), .q_pend1(q_pend1), .q_pend2(q_pend2),
      .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: each source is a queue of {sel, data}; rr_last names the last winner.
   int               m_sel  [2][$];
   int               m_data [2][$];
   int               m_rr_last;
   bit               m_err;
   bit               m_init = 0;

   logic             o_wr_en, o_err, o_pend1, o_pend2, o_ready0;
   logic [SELW-1:0]  o_wr_sel;
   logic [REGWIDTH-1:0] o_wr_data;
   int               wlog[$];
   int               full_seen;

   function automatic bit m_has(input int src, input int sel);
      foreach (m_sel[src][k]) if (m_sel[src][k] == sel) return 1'b1;
      return 1'b0;
   endfunction

   task automatic cyc(input bit r,
                      input bit v0, input int sl0, input int d0,
                      input bit v1, input int sl1, input int d1,
                      input int qa, input int qb);
      int g;
      int e_sel, e_data;
      bit e_rdy0, e_rdy1, acc0, acc1, err_nx;
      @(negedge clk);
      rst = r;
      s0_valid = v0; s0_sel = SELW'(sl0); s0_data = REGWIDTH'(d0);
      s1_valid = v1; s1_sel = SELW'(sl1); s1_data = REGWIDTH'(d1);
      q_sel1 = SELW'(qa); q_sel2 = SELW'(qb);
      #1;
      e_rdy0 = !r && (m_sel[0].size() != DEPTH);
      e_rdy1 = !r && (m_sel[1].size() != DEPTH);
      g = -1;
      if (!r) begin
         if (m_sel[0].size() > 0 && m_sel[1].size() > 0) g = 1 - m_rr_last;
         else if (m_sel[0].size() > 0) g = 0;
         else if (m_sel[1].size() > 0) g = 1;
      end
      e_sel  = (g >= 0) ? m_sel[g][0]  : 0;
      e_data = (g >= 0) ? m_data[g][0] : 0;
      o_wr_en = wr_en; o_wr_sel = wr_sel; o_wr_data = wr_data;
      o_err = err; o_pend1 = q_pend1; o_pend2 = q_pend2; o_ready0 = s0_ready;
      if (o_wr_en === 1'b1) wlog.push_back(int'(o_wr_sel));
      if (!r && o_ready0 === 1'b0) full_seen++;
      chk("s0_ready", s0_ready, e_rdy0);
      chk("s1_ready", s1_ready, e_rdy1);
      chk("wr_en", wr_en, g >= 0);
      if (m_init || r) begin
         chk("q_pend1", q_pend1, !r && (m_has(0, qa) || m_has(1, qa)));
         chk("q_pend2", q_pend2, !r && (m_has(0, qb) || m_has(1, qb)));
      end
      if (m_init) begin
         chk("wr_sel", wr_sel, e_sel);
         chk("wr_data", wr_data, e_data);
         chk("err", err, m_err);
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 2; i++) begin
            m_sel[i].delete();
            m_data[i].delete();
         end
         m_rr_last = 1;
         m_err = 0;
         m_init = 1;
      end else begin
         acc0 = v0 && e_rdy0;
         acc1 = v1 && e_rdy1;
         err_nx = (acc0 && m_has(1, sl0)) || (acc1 && m_has(0, sl1)) ||
                  (acc0 && acc1 && sl0 == sl1);
         if (g >= 0) begin
            void'(m_sel[g].pop_front());
            void'(m_data[g].pop_front());
            m_rr_last = g;
         end
         if (acc0) begin m_sel[0].push_back(sl0); m_data[0].push_back(d0); end
         if (acc1) begin m_sel[1].push_back(sl1); m_data[1].push_back(d1); end
         m_err = err_nx;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; s0_valid = 0; s1_valid = 0; s0_sel = 0; s1_sel = 0;
      s0_data = 0; s1_data = 0; q_sel1 = 0; q_sel2 = 0;
      full_seen = 0;

      // Reset for two cycles, then ready rises on release.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_ready0", o_ready0, 1'b0);
      chk("rst_err", o_err, 1'b0);
      idle(1);
      chk("rel_ready0", o_ready0, 1'b1);

      // Single write appears exactly one cycle after acceptance.
      cyc(0, 1, 3, 16'hBEEF, 0, 0, 0, 0, 0);
      chk("t2_pre_en", o_wr_en, 1'b0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_en", o_wr_en, 1'b1);
      chk("t2_sel", o_wr_sel, 3);
      chk("t2_data", o_wr_data, 16'hBEEF);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_once", o_wr_en, 1'b0);

      // Interleave order after reset favours src0 first.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      wlog.delete();
      cyc(0, 1, 1, 1, 1, 5, 5, 0, 0);
      cyc(0, 1, 2, 2, 1, 6, 6, 0, 0);
      idle(4);
      chk("t3_count", wlog.size(), 4);
      if (wlog.size() == 4) begin
         chk("t3_w0", wlog[0], 1);
         chk("t3_w1", wlog[1], 5);
         chk("t3_w2", wlog[2], 2);
         chk("t3_w3", wlog[3], 6);
      end

      // Both sources pushing every cycle forces src0 full; nothing lost or duplicated.
      wlog.delete();
      full_seen = 0;
      for (int k = 0; k < 5; k++) cyc(0, 1, k, 16'h100 + k, 1, 7 - k, 16'h200 + k, 0, 0);
      idle(8);
      chk("t4_full_seen", full_seen > 0, 1'b1);

      // Pending query sees a buffered src1 write, then clears after drain.
      cyc(0, 0, 0, 0, 1, 4, 16'h44, 4, 2);
      cyc(0, 0, 0, 0, 0, 0, 0, 4, 2);
      chk("t5_pend1", o_pend1, 1'b1);
      chk("t5_pend2", o_pend2, 1'b0);
      cyc(0, 0, 0, 0, 0, 0, 0, 4, 2);
      chk("t5_drained", o_pend1, 1'b0);

      // Cross-source WAW raises err for one cycle.
      cyc(0, 1, 7, 16'h70, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 7, 16'h71, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_err", o_err, 1'b1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_err_pulse", o_err, 1'b0);

      // Mid-operation reset discards buffered entries.
      cyc(0, 1, 1, 16'h11, 1, 3, 16'h33, 1, 3);
      cyc(0, 1, 5, 16'h55, 1, 6, 16'h66, 1, 3);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 3);
      chk("t6_rst_en", o_wr_en, 1'b0);
      chk("t6_rst_pend1", o_pend1, 1'b0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 3);
      chk("t6_post_en", o_wr_en, 1'b0);
      chk("t6_post_pend1", o_pend1, 1'b0);
      chk("t6_post_pend2", o_pend2, 1'b0);

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         cyc(($urandom_range(0, 59) == 0),
             ($urandom_range(0, 2) != 0), $urandom_range(0, 7), $urandom_range(0, 65535),
             ($urandom_range(0, 2) != 0), $urandom_range(0, 7), $urandom_range(0, 65535),
             $urandom_range(0, 7), $urandom_range(0, 7));
      end
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
